// File: rtl/ram_stream_loader_if.sv
// ram_stream_loader_if
//   Groups the byte-stream handshake and the RAM write port of the loader.
//
//   Handshake: a byte transfers on a rising Clk edge where byte_valid and
//   byte_ready are both high. The source holds byte_in stable and keeps
//   byte_valid high until that edge. byte_ready does not depend on
//   byte_valid.
//
//   Signals
//     byte_in        8       stream data (source -> loader)
//     byte_valid     1       byte_in valid (source -> loader)
//     byte_ready     1       loader accepts byte this cycle (loader -> source)
//     wr_data        DATA_W  RAM write data (loader -> RAM data_In)
//     write_address  ADDR_W  RAM write address (loader -> RAM)
//     we             1       RAM write strobe (loader -> RAM)
//   Modports: master = loader side, slave = stream source / RAM side.
interface ram_stream_loader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 19
);
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] write_address;
  logic              we;

  modport master (
    input  byte_in, byte_valid,
    output byte_ready, wr_data, write_address, we
  );

  modport slave (
    output byte_in, byte_valid,
    input  byte_ready, wr_data, write_address, we
  );
endinterface

// File: rtl/ram_stream_loader.sv
// ram_stream_loader
//   Write-side master for single-write-port RAMs. Takes a byte stream and
//   unpacks each byte into 8/DATA_W RAM words, MSB-first, written at
//   consecutive addresses starting at base_addr. Used to reload sprite/map/
//   collision images at run time.
//
//   Optional feature: define LOADER_CHECKSUM_EN to require one trailing
//   checksum byte after the last word; error is raised if the 8-bit sum of
//   all data bytes plus the checksum byte is not zero mod 256.
//
//   Ports
//     Clk         system clock, rising edge
//     Reset_n     asynchronous active-low reset
//     start       load request, sampled only in IDLE
//     base_addr   first RAM address, latched on accepted start
//     word_count  number of RAM words to write, latched on accepted start
//     busy        load in progress
//     done        one-cycle completion pulse
//     error       sticky fault flag, cleared by the next accepted start
//     state_dbg   current FSM state encoding
//     bus         stream handshake + RAM write port (master modport)
module ram_stream_loader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 19,
  parameter int DEPTH  = 76800
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        state_dbg,
  ram_stream_loader_if.master bus
);

  localparam logic [3:0]      WPB     = 4'(8 / DATA_W);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RECV   = 3'd1,
    S_UNPACK = 3'd2,
    S_FINISH = 3'd3
`ifdef LOADER_CHECKSUM_EN
    ,S_CHECK = 3'd4
`endif
  } state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] addr_q, remaining_q, wr_addr_q;
  logic [7:0]        shreg_q;
  logic [3:0]        slice_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              we_q, error_q, byte_ready_c;
  logic              range_bad, more_slices;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum_q;
`endif

  // One bit wider than the address so base+count cannot wrap.
  assign range_bad = ({1'b0, base_addr} + {1'b0, word_count}) > DEPTH_X;
  // Another word of the held byte is due this cycle.
  assign more_slices = (remaining_q != '0) && (slice_q != WPB);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n      = state;
    byte_ready_c = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (word_count == '0) state_n = S_FINISH;
          else if (!range_bad)  state_n = S_RECV;
        end
      end
      S_RECV: begin
        byte_ready_c = 1'b1;
        busy         = 1'b1;
        if (bus.byte_valid) state_n = S_UNPACK;
      end
      S_UNPACK: begin
        busy = 1'b1;
        if (remaining_q == '0) begin
`ifdef LOADER_CHECKSUM_EN
          state_n = S_CHECK;
`else
          state_n = S_FINISH;
`endif
        end else if (slice_q == WPB) begin
          state_n = S_RECV;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        byte_ready_c = 1'b1;
        busy         = 1'b1;
        if (bus.byte_valid) state_n = S_FINISH;
      end
`endif
      S_FINISH: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      addr_q      <= '0;
      remaining_q <= '0;
      wr_addr_q   <= '0;
      shreg_q     <= '0;
      slice_q     <= '0;
      wr_data_q   <= '0;
      we_q        <= 1'b0;
      error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr_q      <= base_addr;
            remaining_q <= word_count;
            // A zero-length load completes without a range check.
            error_q     <= (word_count != '0) && range_bad;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
          end
        end
        S_RECV: begin
          if (bus.byte_valid) begin
            wr_data_q   <= bus.byte_in[7 -: DATA_W];
            wr_addr_q   <= addr_q;
            we_q        <= 1'b1;
            addr_q      <= addr_q + ADDR_W'(1);
            remaining_q <= remaining_q - ADDR_W'(1);
            shreg_q     <= bus.byte_in << DATA_W;
            slice_q     <= 4'd1;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= sum_q + bus.byte_in;
`endif
          end
        end
        S_UNPACK: begin
          if (more_slices) begin
            wr_data_q   <= shreg_q[7 -: DATA_W];
            wr_addr_q   <= addr_q;
            we_q        <= 1'b1;
            addr_q      <= addr_q + ADDR_W'(1);
            remaining_q <= remaining_q - ADDR_W'(1);
            shreg_q     <= shreg_q << DATA_W;
            slice_q     <= slice_q + 4'd1;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (bus.byte_valid && (8'(sum_q + bus.byte_in) != 8'd0)) error_q <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.byte_ready    = byte_ready_c;
  assign bus.wr_data       = wr_data_q;
  assign bus.write_address = wr_addr_q;
  assign bus.we            = we_q;
  assign error             = error_q;
  assign state_dbg         = state;

endmodule

// File: tb/tb_ram_stream_loader.sv
// tb_ram_stream_loader
//   Directed bench for ram_stream_loader. Three instances (DATA_W = 8, 4, 1)
//   share clock and reset; each is driven through its own interface.
module tb_ram_stream_loader;
  localparam int AW = 19;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  logic          start_s[3];
  logic [AW-1:0] base_s[3];
  logic [AW-1:0] cnt_s[3];
  logic          busy_w[3];
  logic          done_w[3];
  logic          err_w[3];
  logic [2:0]    st_w[3];

  ram_stream_loader_if #(.DATA_W(8), .ADDR_W(AW)) b8 ();
  ram_stream_loader_if #(.DATA_W(4), .ADDR_W(AW)) b4 ();
  ram_stream_loader_if #(.DATA_W(1), .ADDR_W(AW)) b1 ();

  ram_stream_loader #(.DATA_W(8), .ADDR_W(AW), .DEPTH(76800)) u8 (
    .Clk(Clk), .Reset_n(Reset_n), .start(start_s[0]), .base_addr(base_s[0]),
    .word_count(cnt_s[0]), .busy(busy_w[0]), .done(done_w[0]), .error(err_w[0]),
    .state_dbg(st_w[0]), .bus(b8));
  ram_stream_loader #(.DATA_W(4), .ADDR_W(AW), .DEPTH(76800)) u4 (
    .Clk(Clk), .Reset_n(Reset_n), .start(start_s[1]), .base_addr(base_s[1]),
    .word_count(cnt_s[1]), .busy(busy_w[1]), .done(done_w[1]), .error(err_w[1]),
    .state_dbg(st_w[1]), .bus(b4));
  ram_stream_loader #(.DATA_W(1), .ADDR_W(AW), .DEPTH(76800)) u1 (
    .Clk(Clk), .Reset_n(Reset_n), .start(start_s[2]), .base_addr(base_s[2]),
    .word_count(cnt_s[2]), .busy(busy_w[2]), .done(done_w[2]), .error(err_w[2]),
    .state_dbg(st_w[2]), .bus(b1));

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  int busy_seen = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ent(input int addr, input int data);
    return {5'd0, AW'(addr), 8'(data)};
  endfunction

  task automatic sb_write(input string tag, input logic [31:0] obs, input logic rdy);
    logic [31:0] e;
    if (we_cnt == 0) first_cyc = cyc;
    last_cyc = cyc;
    we_cnt++;
    check({tag, "_rdy_low"}, 32'(rdy), 32'd0);
    check({tag, "_expected"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  always @(negedge Clk) begin
    cyc++;
    if (b8.we) sb_write("w8", {5'd0, b8.write_address, b8.wr_data}, b8.byte_ready);
    if (b4.we) sb_write("w4", {5'd0, b4.write_address, 4'd0, b4.wr_data}, b4.byte_ready);
    if (b1.we) sb_write("w1", {5'd0, b1.write_address, 7'd0, b1.wr_data}, b1.byte_ready);
    if (done_w[0] || done_w[1] || done_w[2]) done_cnt++;
    if (busy_w[0] || busy_w[1] || busy_w[2]) busy_seen++;
  end

  task automatic reset_counters();
    we_cnt = 0;
    done_cnt = 0;
    busy_seen = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_byte(input int w, input logic [7:0] b, input logic v);
    case (w)
      0: begin b8.byte_in = b; b8.byte_valid = v; end
      1: begin b4.byte_in = b; b4.byte_valid = v; end
      default: begin b1.byte_in = b; b1.byte_valid = v; end
    endcase
  endtask

  function automatic logic rdy(input int w);
    case (w)
      0: return b8.byte_ready;
      1: return b4.byte_ready;
      default: return b1.byte_ready;
    endcase
  endfunction

  task automatic start_load(input int w, input int base, input int count);
    start_s[w] = 1'b1;
    base_s[w] = AW'(base);
    cnt_s[w] = AW'(count);
    @(negedge Clk);
    start_s[w] = 1'b0;
  endtask

  task automatic send(input int w, input logic [7:0] b, input int gap);
    int n = 0;
    set_byte(w, 8'h00, 1'b0);
    repeat (gap) @(negedge Clk);
    set_byte(w, b, 1'b1);
    while (!rdy(w) && n < 40) begin
      @(negedge Clk);
      n++;
    end
    check("byte_taken", 32'(n < 40), 32'd1);
    @(negedge Clk);
    set_byte(w, 8'h00, 1'b0);
  endtask

  task automatic wait_done(input int w);
    int n = 0;
    while (!done_w[w] && n < 40) begin
      @(negedge Clk);
      n++;
    end
    check("done_seen", 32'(n < 40), 32'd1);
    @(negedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      base_s[i] = '0;
      cnt_s[i] = '0;
    end
    set_byte(0, 8'h00, 1'b0);
    set_byte(1, 8'h00, 1'b0);
    set_byte(2, 8'h00, 1'b0);

    // Reset state
    repeat (3) @(negedge Clk);
    check("rst_we", 32'(b8.we), 32'd0);
    check("rst_busy", 32'(busy_w[0]), 32'd0);
    check("rst_done", 32'(done_w[0]), 32'd0);
    check("rst_error", 32'(err_w[0]), 32'd0);
    check("rst_ready", 32'(b8.byte_ready), 32'd0);
    check("rst_wr_data", 32'(b8.wr_data), 32'd0);
    check("rst_addr", 32'(b8.write_address), 32'd0);
    check("rst_state", 32'(st_w[0]), 32'd0);
    Reset_n = 1'b1;
    @(negedge Clk);

    // DATA_W=8, three bytes back to back
    reset_counters();
    exp_q.push_back(ent(100, 8'h12));
    exp_q.push_back(ent(101, 8'h34));
    exp_q.push_back(ent(102, 8'h56));
    start_load(0, 100, 3);
    check("t1_busy", 32'(busy_w[0]), 32'd1);
    send(0, 8'h12, 0);
    send(0, 8'h34, 0);
    send(0, 8'h56, 0);
    wait_done(0);
    check("t1_we_cnt", 32'(we_cnt), 32'd3);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_busy_after", 32'(busy_w[0]), 32'd0);
    check("t1_error", 32'(err_w[0]), 32'd0);
    check("t1_drained", 32'(exp_q.size()), 32'd0);

    // DATA_W=4, count 3: low nibble of CDh discarded
    reset_counters();
    exp_q.push_back(ent(0, 4'hA));
    exp_q.push_back(ent(1, 4'hB));
    exp_q.push_back(ent(2, 4'hC));
    start_load(1, 0, 3);
    send(1, 8'hAB, 0);
    send(1, 8'hCD, 0);
    wait_done(1);
    check("t2_we_cnt", 32'(we_cnt), 32'd3);
    check("t2_done_cnt", 32'(done_cnt), 32'd1);
    check("t2_drained", 32'(exp_q.size()), 32'd0);

    // DATA_W=1, A5h -> 1,0,1,0,0,1,0,1 at 8..15 on consecutive cycles
    reset_counters();
    exp_q.push_back(ent(8, 1));
    exp_q.push_back(ent(9, 0));
    exp_q.push_back(ent(10, 1));
    exp_q.push_back(ent(11, 0));
    exp_q.push_back(ent(12, 0));
    exp_q.push_back(ent(13, 1));
    exp_q.push_back(ent(14, 0));
    exp_q.push_back(ent(15, 1));
    start_load(2, 8, 8);
    send(2, 8'hA5, 0);
    wait_done(2);
    check("t3_we_cnt", 32'(we_cnt), 32'd8);
    check("t3_span", 32'(last_cyc - first_cyc), 32'd7);
    check("t3_done_cnt", 32'(done_cnt), 32'd1);
    check("t3_drained", 32'(exp_q.size()), 32'd0);

    // Range error at top of RAM, then cleared by a good start
    reset_counters();
    start_load(0, 76799, 2);
    check("t4_error", 32'(err_w[0]), 32'd1);
    check("t4_busy", 32'(busy_w[0]), 32'd0);
    repeat (3) @(negedge Clk);
    check("t4_err_sticky", 32'(err_w[0]), 32'd1);
    check("t4_busy_never", 32'(busy_seen), 32'd0);
    check("t4_no_we", 32'(we_cnt), 32'd0);
    check("t4_no_done", 32'(done_cnt), 32'd0);
    exp_q.push_back(ent(0, 8'h77));
    start_load(0, 0, 1);
    check("t4_err_clear", 32'(err_w[0]), 32'd0);
    send(0, 8'h77, 0);
    wait_done(0);
    check("t4_drained", 32'(exp_q.size()), 32'd0);

    // Valid gaps plus a stray start while busy
    reset_counters();
    exp_q.push_back(ent(100, 8'h12));
    exp_q.push_back(ent(101, 8'h34));
    exp_q.push_back(ent(102, 8'h56));
    start_load(0, 100, 3);
    send(0, 8'h12, 1);
    start_load(0, 500, 1);
    send(0, 8'h34, 1);
    send(0, 8'h56, 1);
    wait_done(0);
    check("t5_we_cnt", 32'(we_cnt), 32'd3);
    check("t5_done_cnt", 32'(done_cnt), 32'd1);
    check("t5_error", 32'(err_w[0]), 32'd0);
    check("t5_drained", 32'(exp_q.size()), 32'd0);

    // Reset during a load, right after the first write
    reset_counters();
    exp_q.push_back(ent(200, 8'hAA));
    start_load(0, 200, 3);
    send(0, 8'hAA, 0);
    #2 Reset_n = 1'b0;
    #1;
    check("t6_we_rst", 32'(b8.we), 32'd0);
    check("t6_busy_rst", 32'(busy_w[0]), 32'd0);
    check("t6_state_rst", 32'(st_w[0]), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    set_byte(0, 8'hBB, 1'b1);
    repeat (5) @(negedge Clk);
    check("t6_rdy_idle", 32'(b8.byte_ready), 32'd0);
    set_byte(0, 8'h00, 1'b0);
    check("t6_we_cnt", 32'(we_cnt), 32'd1);
    check("t6_drained", 32'(exp_q.size()), 32'd0);

`ifdef LOADER_CHECKSUM_EN
    // Checksum good: 01h + 02h + FDh = 0 mod 256
    reset_counters();
    exp_q.push_back(ent(10, 8'h01));
    exp_q.push_back(ent(11, 8'h02));
    start_load(0, 10, 2);
    send(0, 8'h01, 0);
    send(0, 8'h02, 0);
    send(0, 8'hFD, 0);
    wait_done(0);
    check("t7_error_good", 32'(err_w[0]), 32'd0);
    check("t7_done_good", 32'(done_cnt), 32'd1);
    check("t7_drained_good", 32'(exp_q.size()), 32'd0);

    // Checksum bad: 01h + 02h + 00h != 0
    reset_counters();
    exp_q.push_back(ent(10, 8'h01));
    exp_q.push_back(ent(11, 8'h02));
    start_load(0, 10, 2);
    send(0, 8'h01, 0);
    send(0, 8'h02, 0);
    send(0, 8'h00, 0);
    wait_done(0);
    check("t7_error_bad", 32'(err_w[0]), 32'd1);
    check("t7_done_bad", 32'(done_cnt), 32'd1);
    check("t7_drained_bad", 32'(exp_q.size()), 32'd0);
`endif

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_stream_loader.md
Name: ram_stream_loader

Overview:
- Write-side master for the single-port-write sprite/map/collision RAMs: consumes a byte stream (UART or host bridge) and drives the RAM write port.
- Drives `wr_data`/`write_address`/`we` to map onto a RAM's `data_In`/`write_address`/`we`.
- Unpacks each byte into 8/DATA_W RAM words, MSB-first, at consecutive addresses from a base.
- Lets the start menu, map and collision images be reloaded at run time without resynthesis.

Parameters:
- DATA_W, 8: RAM word width; legal values 1, 4, 8.
- ADDR_W, 19: RAM address width.
- DEPTH, 76800: number of valid RAM words; writes never reach address >= DEPTH.

Ports:
- Clk  in  1  system clock, all state on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- start  in  1  load request, sampled only in IDLE.
- base_addr  in  ADDR_W  first RAM address, latched on accepted start.
- word_count  in  ADDR_W  number of RAM words to write, latched on accepted start.
- byte_in  in  8  stream data.
- byte_valid  in  1  byte_in valid.
- byte_ready  out  1  loader accepts byte this cycle.
- wr_data  out  DATA_W  RAM write data.
- write_address  out  ADDR_W  RAM write address.
- we  out  1  RAM write strobe.
- busy  out  1  load in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky fault flag, cleared on next accepted start.

Behaviour:
- Reset (async assert): state=IDLE. All outputs 0: byte_ready, wr_data, write_address, we, busy, done, error. Internal counters 0.
- WPB = 8/DATA_W words per byte. Address and remaining counters are ADDR_W wide, unsigned.
- Range check uses ADDR_W+1-bit arithmetic, so no wrap.
- IDLE, start=1: latch base/count, clear error, then:
  - word_count==0: done=1 next cycle, no writes.
  - base_addr+word_count > DEPTH: error=1, no writes, stay IDLE.
  - otherwise: go to RECV, busy=1.
- start while not IDLE: ignored.
- RECV: byte_ready=1 (combinational from state). Byte accepted on an edge where byte_valid && byte_ready.
  - At that edge: byte latched; wr_data = byte[7:8-DATA_W]; write_address = current address; we=1; state -> UNPACK.
- UNPACK: byte_ready=0. One word written per cycle while we=1.
  - Each edge: address+1, remaining-1, next slice loaded MSB-first.
  - After the WPB-th word: if remaining>0, -> RECV with we=0.
  - When remaining reaches 0 mid-byte: leftover low slices discarded; -> FINISH, or CHECK if checksum enabled.
- Latency/throughput:
  - First write is visible in the cycle immediately after the acceptance edge.
  - Max throughput is one byte per WPB+1 cycles. byte_valid gaps simply extend RECV.
- FINISH: we=0, busy=0, done=1 for exactly one cycle, -> IDLE.
- Write addresses always lie within [base_addr, base_addr+word_count-1], strictly increasing by 1.
- Reset_n low mid-load: immediate return to IDLE; no further we. RAM keeps the partially written contents.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - Loader keeps an 8-bit running sum (mod 256) of every accepted data byte, cleared on start.
  - After the last word, state CHECK asserts byte_ready and accepts one trailing checksum byte.
  - error=1 if (sum + checksum_byte) mod 256 != 0.
  - Then FINISH; done pulses regardless of error.
- Not defined: no CHECK state, no trailing byte; error is raised only by the range check.

Test Plan:
- DATA_W=8, base=100, count=3, bytes 12h,34h,56h with byte_valid held high:
  - Required writes: (100,12h), (101,34h), (102,56h), each with we for one cycle.
  - byte_ready low during each write cycle; done pulses once; busy low after; error=0.
- DATA_W=4, base=0, count=3, bytes ABh,CDh:
  - Required writes: (0,Ah), (1,Bh), (2,Ch); nibble Dh never written.
  - Exactly 3 we cycles; done=1.
- DATA_W=1, base=8, count=8, byte A5h:
  - Required writes: addresses 8..15 receive 1,0,1,0,0,1,0,1 on 8 consecutive cycles.
- DEPTH=76800, base=76799, count=2:
  - Required: error=1 next cycle, no we, busy never high.
  - A following start with base=0, count=1 clears error.
- Valid gaps and stray start:
  - Stimulus: byte_valid toggled every other cycle, start pulsed while busy.
  - Required: write sequence identical to the no-gap case; the extra start has no effect.
- Reset_n dropped after the first of 3 writes:
  - Required: we=0 and busy=0 immediately; later bytes not accepted.
- With LOADER_CHECKSUM_EN, DATA_W=8, count=2, bytes 01h,02h:
  - Checksum byte FDh -> error=0.
  - Checksum byte 00h -> error=1.
  - done pulses in both cases.
